// File: rtl/steer_quad_multi_if.sv
// Bus bundle for the multi-channel steering converter: shared controls in,
// per-channel quadrature pairs, step strobes and position counters out.
interface steer_quad_multi_if #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 16,
  parameter int POS_W    = 8
);
  logic [DIV_W-1:0]          clkdiv;
  logic [CHANNELS-1:0]       left;
  logic [CHANNELS-1:0]       right;
  logic                      pos_clr;
  logic [2*CHANNELS-1:0]     steer;
  logic [CHANNELS-1:0]       step;
  logic [POS_W*CHANNELS-1:0] pos;

  modport master (
    output clkdiv, left, right, pos_clr,
    input  steer, step, pos
  );

  modport slave (
    input  clkdiv, left, right, pos_clr,
    output steer, step, pos
  );
endinterface

// File: rtl/steer_quad_multi.sv
// Joystick-to-quadrature steering for N players with per-channel acceleration
// ramp, signed wheel-position counters, step strobes and a global clear.
module steer_quad_multi #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_EVERY = 8,
  parameter int ACCEL_MAX   = 2,
  parameter int POS_W       = 8
) (
  input  logic              CLK,
  input  logic              reset,
  steer_quad_multi_if.slave bus
);

  localparam int SC_W = (ACCEL_EVERY > 1) ? $clog2(ACCEL_EVERY) : 1;
  localparam int SH_W = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(ACCEL_EVERY - 1);
  localparam logic [SH_W-1:0] SH_MAX  = SH_W'(ACCEL_MAX);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A zero divider behaves as one so the wheel still turns at full rate.
  logic [DIV_W-1:0] div_eff;
  assign div_eff = (bus.clkdiv == '0) ? DIV_W'(1) : bus.clkdiv;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [0:0]       state_q,  state_d;
    logic             dir_q,    dir_d;     // 1 = right
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic [SH_W-1:0]  shift_q,  shift_d;
    logic [SC_W-1:0]  scount_q, scount_d;
    logic [1:0]       steer_q,  steer_d;   // the Gray phase itself
    logic             step_q,   step_d;
    logic [POS_W-1:0] pos_q,    pos_d;
    logic [DIV_W-1:0] period;
    logic             req;
    logic             req_right;

    assign req       = bus.left[c] ^ bus.right[c];
    assign req_right = bus.right[c];

    // NOTE: every variable gets a default at the top of always_comb so that
    // no path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      scount_d = scount_q;
      steer_d  = steer_q;
      step_d   = 1'b0;
      pos_d    = pos_q;
      period   = '0;

      if (state_q == ST_IDLE) begin
        if (req) begin
          state_d  = ST_RUN;
          dir_d    = req_right;
          shift_d  = '0;
          scount_d = '0;
          cnt_d    = div_eff - 1'b1;
        end
      end else if (!req) begin
        state_d  = ST_IDLE;
        shift_d  = '0;
        scount_d = '0;
        cnt_d    = '0;
      end else if (req_right != dir_q) begin
        // Reversal restarts the ramp exactly like a fresh entry.
        dir_d    = req_right;
        shift_d  = '0;
        scount_d = '0;
        cnt_d    = div_eff - 1'b1;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        step_d  = 1'b1;
        steer_d = dir_q ? {steer_q[0], ~steer_q[1]} : {~steer_q[0], steer_q[1]};
        pos_d   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
        if (scount_q == SC_LAST) begin
          scount_d = '0;
          if (shift_q != SH_MAX) shift_d = shift_q + 1'b1;
        end else begin
          scount_d = scount_q + 1'b1;
        end
        period = div_eff >> shift_d;
        if (period == '0) period = DIV_W'(1);
        cnt_d = period - 1'b1;
      end

      if (bus.pos_clr) pos_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        dir_q    <= 1'b0;
        cnt_q    <= '0;
        shift_q  <= '0;
        scount_q <= '0;
        steer_q  <= 2'b00;
        step_q   <= 1'b0;
        pos_q    <= '0;
      end else begin
        state_q  <= state_d;
        dir_q    <= dir_d;
        cnt_q    <= cnt_d;
        shift_q  <= shift_d;
        scount_q <= scount_d;
        steer_q  <= steer_d;
        step_q   <= step_d;
        pos_q    <= pos_d;
      end
    end

    assign bus.steer[2*c +: 2]     = steer_q;
    assign bus.step[c]             = step_q;
    assign bus.pos[POS_W*c +: POS_W] = pos_q;
  end

endmodule

// File: tb/tb_steer_quad_multi.sv
// Self-checking bench: two DUT builds (with and without acceleration) share
// one stimulus stream and are compared every cycle to a behavioural model.
module tb_steer_quad_multi;
  localparam int CH = 2;
  localparam int DW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_v;
  logic [DW-1:0] clkdiv_v;
  logic [CH-1:0] left_v, right_v;
  logic          clr_v;

  steer_quad_multi_if #(.CHANNELS(CH), .DIV_W(DW), .POS_W(PW)) bus_a ();
  steer_quad_multi_if #(.CHANNELS(CH), .DIV_W(DW), .POS_W(PW)) bus_b ();

  assign bus_a.clkdiv = clkdiv_v;  assign bus_b.clkdiv = clkdiv_v;
  assign bus_a.left   = left_v;    assign bus_b.left   = left_v;
  assign bus_a.right  = right_v;   assign bus_b.right  = right_v;
  assign bus_a.pos_clr = clr_v;    assign bus_b.pos_clr = clr_v;

  steer_quad_multi #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_EVERY(2), .ACCEL_MAX(2), .POS_W(PW))
    dut_a (.CLK(clk), .reset(reset_v), .bus(bus_a));
  steer_quad_multi #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_EVERY(2), .ACCEL_MAX(0), .POS_W(PW))
    dut_b (.CLK(clk), .reset(reset_v), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: wheel phase as an index into the Gray sequence, position
  // kept modulo 256, and a countdown of cycles to the next step.
  int ae[2]  = '{2, 2};
  int am[2]  = '{2, 0};
  int seq[4] = '{0, 1, 3, 2};
  int m_act[2][CH], m_dir[2][CH], m_wait[2][CH], m_sc[2][CH];
  int m_sh[2][CH], m_ph[2][CH], m_pos[2][CH], m_step[2][CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int eff;
    int p;
    eff = (clkdiv_v == 0) ? 1 : int'(clkdiv_v);
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        m_step[i][c] = 0;
        if (reset_v) begin
          m_act[i][c] = 0; m_dir[i][c] = 0; m_wait[i][c] = 0; m_sc[i][c] = 0;
          m_sh[i][c]  = 0; m_ph[i][c]  = 0; m_pos[i][c]  = 0;
        end else begin
          if (left_v[c] == right_v[c]) begin
            m_act[i][c] = 0; m_sh[i][c] = 0; m_sc[i][c] = 0;
          end else if (m_act[i][c] == 0 || int'(right_v[c]) != m_dir[i][c]) begin
            m_act[i][c] = 1; m_dir[i][c] = int'(right_v[c]);
            m_sh[i][c] = 0; m_sc[i][c] = 0; m_wait[i][c] = eff - 1;
          end else if (m_wait[i][c] > 0) begin
            m_wait[i][c]--;
          end else begin
            m_step[i][c] = 1;
            m_ph[i][c]  = (m_ph[i][c] + (m_dir[i][c] != 0 ? 1 : 3)) % 4;
            m_pos[i][c] = (m_pos[i][c] + (m_dir[i][c] != 0 ? 1 : 255)) % 256;
            m_sc[i][c]++;
            if (m_sc[i][c] == ae[i]) begin
              m_sc[i][c] = 0;
              if (m_sh[i][c] < am[i]) m_sh[i][c]++;
            end
            p = eff >> m_sh[i][c];
            if (p < 1) p = 1;
            m_wait[i][c] = p - 1;
          end
          if (clr_v) m_pos[i][c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("a.steer[%0d]", c), 32'(bus_a.steer[2*c +: 2]),   32'(seq[m_ph[0][c]]));
      check($sformatf("a.step[%0d]", c),  32'(bus_a.step[c]),           32'(m_step[0][c]));
      check($sformatf("a.pos[%0d]", c),   32'(bus_a.pos[PW*c +: PW]),   32'(m_pos[0][c]));
      check($sformatf("b.steer[%0d]", c), 32'(bus_b.steer[2*c +: 2]),   32'(seq[m_ph[1][c]]));
      check($sformatf("b.step[%0d]", c),  32'(bus_b.step[c]),           32'(m_step[1][c]));
      check($sformatf("b.pos[%0d]", c),   32'(bus_b.pos[PW*c +: PW]),   32'(m_pos[1][c]));
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int step_t[6]  = '{5, 9, 11, 13, 14, 15};
  int steer_t[6] = '{1, 3, 2, 0, 1, 3};

  initial begin
    int k;
    logic hit;
    logic reached;

    // Reset held with a right request pending on channel 0.
    reset_v = 1'b1; clkdiv_v = 16'd4; left_v = '0; right_v = 2'b01; clr_v = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("reset_steer", 32'(bus_a.steer), 32'd0);
    check("reset_pos",   32'(bus_a.pos),   32'd0);

    // Ramp on channel 0: clkdiv 4, rate doubles every 2 steps up to shift 2.
    reset_v = 1'b0;
    k = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      hit = 1'b0;
      for (int j = 0; j < 6; j++) begin
        if (step_t[j] == t) begin
          hit = 1'b1;
          check($sformatf("ramp_steer_t%0d", t), 32'(bus_a.steer[1:0]), 32'(steer_t[j]));
          k++;
          check($sformatf("ramp_pos_t%0d", t), 32'(bus_a.pos[PW-1:0]), 32'(k));
        end
      end
      check($sformatf("ramp_step_t%0d", t), 32'(bus_a.step[0]), 32'(hit));
      check($sformatf("ramp_ch1_t%0d", t),  32'(bus_a.steer[3:2]), 32'd0);
    end

    // Release, then channel 1 left at clkdiv 3 (no-accel build keeps the rate).
    right_v = '0;
    tick(); tick();
    clkdiv_v = 16'd3; left_v = 2'b10;
    for (int i = 0; i < 14; i++) tick();
    check("left_b_pos1", 32'(bus_b.pos[2*PW-1:PW]), 32'(8'hFC));

    // Both directions on channel 0, clkdiv 0 with right on channel 1.
    left_v = 2'b01; right_v = 2'b11; clkdiv_v = '0;
    for (int i = 0; i < 10; i++) tick();
    check("both_no_step", 32'(bus_a.step[0]), 32'd0);

    // Reversal mid-ramp on channel 0.
    left_v = '0; right_v = '0; tick();
    clkdiv_v = 16'd8; right_v = 2'b01;
    for (int i = 0; i < 30; i++) tick();
    left_v = 2'b01; right_v = '0;
    tick();
    check("rev_no_step", 32'(bus_a.step[0]), 32'd0);
    for (int i = 0; i < 20; i++) tick();

    // Position wrap and clear coinciding with a step.
    left_v = '0; right_v = '0; clr_v = 1'b1; tick();
    clr_v = 1'b0; clkdiv_v = 16'd1; right_v = 2'b01;
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      tick();
      if (m_pos[0][0] == 127) reached = 1'b1;
    end
    check("wrap_reach127", 32'(reached), 32'd1);
    clr_v = 1'b1; tick(); clr_v = 1'b0;
    check("clr_pos",  32'(bus_a.pos[PW-1:0]), 32'd0);
    check("clr_step", 32'(bus_a.step[0]),     32'd1);
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      tick();
      if (m_pos[0][0] == 127) reached = 1'b1;
    end
    check("wrap_reach127b", 32'(reached), 32'd1);
    tick();
    check("wrap_pos", 32'(bus_a.pos[PW-1:0]), 32'(8'h80));

    // Randomised traffic across both channels.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) left_v  = CH'($urandom);
      if ($urandom_range(7) == 0) right_v = CH'($urandom);
      if ($urandom_range(31) == 0) clkdiv_v = DW'($urandom_range(5));
      clr_v   = ($urandom_range(31) == 0);
      reset_v = ($urandom_range(199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
